// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: pairing FSM states, byte framing constant
// and the bit-to-amplitude mapping reused by the demodulator model.
package qpsk_pkg;

    typedef enum logic {
        WAIT_I = 1'b0,
        WAIT_Q = 1'b1
    } pair_state_e;

    localparam int SYMS_PER_BYTE = 4;

    // 0 -> +amp, 1 -> -amp; amp is clamped to what a signed w-bit word holds.
    function automatic logic signed [31:0] map_bit(
        input logic b,
        input int   amp,
        input int   w
    );
        int lim;
        int a;
        lim = (1 << (w - 1)) - 1;
        a   = (amp > lim) ? lim : amp;
        return b ? -a : a;
    endfunction

endpackage

// File: rtl/qpsk_dibit_mapper.sv
// Pairs a serial bit stream into I/Q dibits and presents one bipolar
// QPSK symbol per dibit on a valid/ready interface.
module qpsk_dibit_mapper
    import qpsk_pkg::*;
#(
    parameter int W   = 8,
    parameter int AMP = 90
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         frame_start,
    output logic         bit_ready,
    output logic [W-1:0] i_out,
    output logic [W-1:0] q_out,
    output logic         sym_valid,
    input  logic         sym_ready,
    output logic         sym_last,
    output logic         align_err
);

    localparam logic signed [31:0] POS32 = map_bit(1'b0, AMP, W);
    localparam logic signed [31:0] NEG32 = map_bit(1'b1, AMP, W);
    localparam logic [W-1:0] POS = POS32[W-1:0];
    localparam logic [W-1:0] NEG = NEG32[W-1:0];
    localparam logic [1:0] LAST_IDX = 2'(SYMS_PER_BYTE - 1);

    pair_state_e  state_q, state_d;
    logic         i_bit_q, i_bit_d;
    logic [W-1:0] i_q, i_d;
    logic [W-1:0] q_q, q_d;
    logic         sym_valid_q, sym_valid_d;
    logic         sym_last_q, sym_last_d;
    logic [1:0]   idx_q, idx_d;
    logic         align_err_q, align_err_d;

    logic bit_fire;
    logic sym_fire;
    logic load;

    // An I bit never needs output space; a Q bit needs the slot free or draining.
    assign bit_ready = (state_q == WAIT_I) || !sym_valid_q || sym_ready;
    assign bit_fire  = bit_valid && bit_ready;
    assign sym_fire  = sym_valid_q && sym_ready;

    always_comb begin
        state_d     = state_q;
        i_bit_d     = i_bit_q;
        i_d         = i_q;
        q_d         = q_q;
        sym_valid_d = sym_valid_q;
        sym_last_d  = sym_last_q;
        idx_d       = idx_q;
        align_err_d = 1'b0;
        load        = 1'b0;

        if (bit_fire) begin
            unique case (1'b1)
                frame_start: begin
                    align_err_d = (state_q == WAIT_Q);
                    i_bit_d     = bit_in;
                    idx_d       = 2'd0;
                    state_d     = WAIT_Q;
                end
                !frame_start && (state_q == WAIT_I): begin
                    i_bit_d = bit_in;
                    state_d = WAIT_Q;
                end
                default: begin
                    load    = 1'b1;
                    state_d = WAIT_I;
                end
            endcase
        end

        if (load) begin
            i_d         = i_bit_q ? NEG : POS;
            q_d         = bit_in ? NEG : POS;
            sym_last_d  = (idx_q == LAST_IDX);
            idx_d       = idx_q + 2'd1;
            sym_valid_d = 1'b1;
        end else if (sym_fire) begin
            sym_valid_d = 1'b0;
            sym_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_I;
            i_bit_q     <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            idx_q       <= 2'd0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_bit_q     <= i_bit_d;
            i_q         <= i_d;
            q_q         <= q_d;
            sym_valid_q <= sym_valid_d;
            sym_last_q  <= sym_last_d;
            idx_q       <= idx_d;
            align_err_q <= align_err_d;
        end
    end

    assign i_out     = i_q;
    assign q_out     = q_q;
    assign sym_valid = sym_valid_q;
    assign sym_last  = sym_last_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_qpsk_dibit_mapper.sv
// Scenario tasks plus a randomized run against a dibit-level reference
// model; a second instance covers the full-scale AMP=127 case.
module tb_qpsk_dibit_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       bit_in, bit_valid, frame_start, sym_ready;
    logic       bit_ready, sym_valid, sym_last, align_err;
    logic [7:0] i_out, q_out;

    logic       bit_b, bv_b, fs_b, sr_b;
    logic       rdy_b, sv_b, sl_b, ae_b;
    logic [7:0] i_b, q_b;

    int tests = 0;
    int fails = 0;

    qpsk_dibit_mapper #(.W(8), .AMP(90)) dut (
        .clk(clk), .rst_n(rst_n),
        .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .bit_ready(bit_ready),
        .i_out(i_out), .q_out(q_out),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_last(sym_last), .align_err(align_err)
    );

    qpsk_dibit_mapper #(.W(8), .AMP(127)) dut127 (
        .clk(clk), .rst_n(rst_n),
        .bit_in(bit_b), .bit_valid(bv_b),
        .frame_start(fs_b), .bit_ready(rdy_b),
        .i_out(i_b), .q_out(q_b),
        .sym_valid(sv_b), .sym_ready(sr_b),
        .sym_last(sl_b), .align_err(ae_b)
    );

    function automatic logic [7:0] amp8(input bit b);
        return b ? 8'(-90) : 8'(90);
    endfunction

    // Drive one cycle: sample bit_ready before the edge, return #1 after it.
    task automatic cyc(input bit bv, input bit b, input bit fs,
                       input bit sr, output bit rdy);
        bit_valid   = bv;
        bit_in      = b;
        frame_start = fs;
        sym_ready   = sr;
        #1;
        rdy = bit_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bit_valid = 1'b0;
        frame_start = 1'b0;
        sym_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0;
        frame_start = 1'b0; sym_ready = 1'b0;
        bv_b = 1'b0; bit_b = 1'b0; fs_b = 1'b0; sr_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({sym_valid, sym_last, align_err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000",
                     {sym_valid, sym_last, align_err});
        end
        tests++;
        if ({i_out, q_out} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: got %h want 0000", {i_out, q_out});
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (bit_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", bit_ready);
        end
    endtask

    task automatic test_basic();
        bit rdy;
        bit bits [4] = '{0, 1, 1, 0};
        for (int k = 0; k < 4; k++) begin
            cyc(1, bits[k], 0, 1, rdy);
            tests++;
            if (rdy !== 1'b1) begin
                fails++;
                $display("FAIL basic_ready bit %0d: got %b want 1", k, rdy);
            end
            tests++;
            if (sym_valid !== k[0]) begin
                fails++;
                $display("FAIL basic_valid bit %0d: got %b want %b",
                         k, sym_valid, k[0]);
            end
            if (k[0]) begin
                tests++;
                if (i_out !== amp8(bits[k-1]) || q_out !== amp8(bits[k])) begin
                    fails++;
                    $display("FAIL basic_sym %0d: got %h,%h want %h,%h", k,
                             i_out, q_out, amp8(bits[k-1]), amp8(bits[k]));
                end
            end
        end
    endtask

    task automatic test_byte_b4();
        bit rdy;
        logic [7:0] byt = 8'hB4;
        for (int k = 0; k < 4; k++) begin
            cyc(1, byt[2*k], k == 0, 1, rdy);
            tests++;
            if (sym_valid !== 1'b0) begin
                fails++;
                $display("FAIL byte_ibit %0d: valid got %b want 0", k, sym_valid);
            end
            cyc(1, byt[2*k+1], 0, 1, rdy);
            tests++;
            if (sym_valid !== 1'b1 || i_out !== amp8(byt[2*k]) ||
                q_out !== amp8(byt[2*k+1]) || sym_last !== (k == 3)) begin
                fails++;
                $display("FAIL byte_sym %0d: got v%b %h,%h l%b want v1 %h,%h l%b",
                         k, sym_valid, i_out, q_out, sym_last,
                         amp8(byt[2*k]), amp8(byt[2*k+1]), k == 3);
            end
        end
    endtask

    task automatic test_backpressure();
        bit rdy;
        do_reset();
        cyc(1, 0, 0, 1, rdy);
        cyc(1, 1, 0, 1, rdy);
        cyc(1, 1, 0, 0, rdy);
        tests++;
        if (rdy !== 1'b1) begin
            fails++;
            $display("FAIL bp_iready: got %b want 1", rdy);
        end
        cyc(1, 0, 0, 0, rdy);
        tests++;
        if (rdy !== 1'b0) begin
            fails++;
            $display("FAIL bp_qready: got %b want 0", rdy);
        end
        tests++;
        if (sym_valid !== 1'b1 || i_out !== amp8(0) || q_out !== amp8(1)) begin
            fails++;
            $display("FAIL bp_hold: got v%b %h,%h want v1 %h,%h",
                     sym_valid, i_out, q_out, amp8(0), amp8(1));
        end
        cyc(1, 0, 0, 1, rdy);
        tests++;
        if (rdy !== 1'b1 || sym_valid !== 1'b1 ||
            i_out !== amp8(1) || q_out !== amp8(0)) begin
            fails++;
            $display("FAIL bp_release: got r%b v%b %h,%h want r1 v1 %h,%h",
                     rdy, sym_valid, i_out, q_out, amp8(1), amp8(0));
        end
        cyc(0, 0, 0, 1, rdy);
        tests++;
        if (sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got %b want 0", sym_valid);
        end
    endtask

    task automatic test_misalign();
        bit rdy;
        int pulses = 0;
        do_reset();
        cyc(1, 1, 0, 1, rdy);
        pulses += int'(align_err);
        cyc(1, 0, 1, 1, rdy);
        tests++;
        if (align_err !== 1'b1 || sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL mis_pulse: got ae%b v%b want ae1 v0",
                     align_err, sym_valid);
        end
        pulses += int'(align_err);
        cyc(1, 1, 0, 1, rdy);
        pulses += int'(align_err);
        tests++;
        if (sym_valid !== 1'b1 || i_out !== amp8(0) ||
            q_out !== amp8(1) || sym_last !== 1'b0) begin
            fails++;
            $display("FAIL mis_sym: got v%b %h,%h l%b want v1 %h,%h l0",
                     sym_valid, i_out, q_out, sym_last, amp8(0), amp8(1));
        end
        for (int k = 1; k < 4; k++) begin
            cyc(1, 0, 0, 1, rdy);
            pulses += int'(align_err);
            cyc(1, 0, 0, 1, rdy);
            pulses += int'(align_err);
            tests++;
            if (sym_valid !== 1'b1 || sym_last !== (k == 3)) begin
                fails++;
                $display("FAIL mis_idx %0d: got v%b l%b want v1 l%b",
                         k, sym_valid, sym_last, k == 3);
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL mis_count: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_reset_midpair();
        bit rdy;
        do_reset();
        cyc(1, 0, 0, 1, rdy);
        cyc(1, 1, 0, 1, rdy);
        cyc(1, 1, 0, 0, rdy);
        rst_n = 1'b0;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({sym_valid, sym_last, align_err, i_out, q_out} !== 19'd0) begin
            fails++;
            $display("FAIL rstmid_out: got v%b l%b ae%b %h,%h want all 0",
                     sym_valid, sym_last, align_err, i_out, q_out);
        end
        rst_n = 1'b1;
        cyc(1, 1, 0, 1, rdy);
        tests++;
        if (sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_stale: got valid %b want 0", sym_valid);
        end
        cyc(1, 1, 0, 1, rdy);
        tests++;
        if (sym_valid !== 1'b1 || i_out !== amp8(1) || q_out !== amp8(1)) begin
            fails++;
            $display("FAIL rstmid_fresh: got v%b %h,%h want v1 %h,%h",
                     sym_valid, i_out, q_out, amp8(1), amp8(1));
        end
    endtask

    task automatic test_amp127();
        do_reset();
        bv_b = 1'b1; bit_b = 1'b1; sr_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bv_b = 1'b0;
        tests++;
        if (sv_b !== 1'b1 || i_b !== 8'h81 || q_b !== 8'h81 ||
            sl_b !== 1'b0 || ae_b !== 1'b0 || rdy_b !== 1'b1) begin
            fails++;
            $display("FAIL amp127: got v%b %h,%h l%b ae%b r%b want v1 81,81 l0 ae0 r1",
                     sv_b, i_b, q_b, sl_b, ae_b, rdy_b);
        end
    endtask

    task automatic test_random();
        bit rdy, exp_rdy, bv, b, fs, sr;
        bit have_i, held, full, last, aerr;
        logic [7:0] ei, eq;
        int cnt;
        do_reset();
        have_i = 0; held = 0; full = 0; last = 0; aerr = 0;
        ei = '0; eq = '0; cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            bv = ($urandom_range(0, 3) != 0);
            b  = 1'($urandom_range(0, 1));
            fs = ($urandom_range(0, 7) == 0);
            sr = ($urandom_range(0, 3) != 0);
            exp_rdy = !have_i || !full || sr;
            cyc(bv, b, fs, sr, rdy);
            tests++;
            if (rdy !== exp_rdy) begin
                fails++;
                $display("FAIL rnd_ready n%0d: got %b want %b", n, rdy, exp_rdy);
            end
            aerr = 0;
            if (bv && exp_rdy) begin
                if (fs) begin
                    aerr = have_i;
                    have_i = 1; held = b; cnt = 0;
                end else if (!have_i) begin
                    have_i = 1; held = b;
                end else begin
                    have_i = 0;
                    ei = amp8(held); eq = amp8(b);
                    last = (cnt % 4) == 3;
                    cnt++;
                    full = 1;
                end
            end else if (full && sr) begin
                full = 0;
            end
            if (bv && exp_rdy && have_i) begin
                if (full && sr) full = 0;
            end
            tests++;
            if (sym_valid !== full || align_err !== aerr) begin
                fails++;
                $display("FAIL rnd_flags n%0d: got v%b ae%b want v%b ae%b",
                         n, sym_valid, align_err, full, aerr);
            end
            if (full) begin
                tests++;
                if (i_out !== ei || q_out !== eq || sym_last !== last) begin
                    fails++;
                    $display("FAIL rnd_sym n%0d: got %h,%h l%b want %h,%h l%b",
                             n, i_out, q_out, sym_last, ei, eq, last);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_b4();
        test_backpressure();
        test_misalign();
        test_reset_midpair();
        test_amp127();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
